// File: rtl/mtm_alu_deserializer.sv
// Serial front end of the mtm_alu: recovers 11-bit frames from sin and assembles
// eight data bytes plus one command byte into a B/A/ctl packet on a valid/ready handshake.
module mtm_alu_deserializer #(
    parameter int DATA_BYTES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sin,
    output logic        pkt_valid,
    input  logic        pkt_ready,
    output logic [31:0] pkt_b,
    output logic [31:0] pkt_a,
    output logic [7:0]  pkt_ctl,
    output logic        pkt_err,
    output logic        frame_err,
    output logic        overrun
);

    localparam logic [3:0] FULL_CNT = 4'(DATA_BYTES);
    localparam logic [3:0] SAT_CNT  = 4'(DATA_BYTES + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_t;

    state_t      state_r, state_s;
    logic [3:0]  bitcnt_r, bitcnt_s;
    logic [8:0]  shift_r, shift_s;
    logic [3:0]  bytecnt_r, bytecnt_s;
    logic [31:0] stage_b_r, stage_b_s;
    logic [31:0] stage_a_r, stage_a_s;
    logic [4:0]  slot_s;
    logic        stop_s, frame_bad_s, data_ok_s, cmd_ok_s;

    // Receiver and assembler state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            bitcnt_r  <= 4'd0;
            shift_r   <= 9'd0;
            bytecnt_r <= 4'd0;
            stage_b_r <= 32'd0;
            stage_a_r <= 32'd0;
        end else begin
            state_r   <= state_s;
            bitcnt_r  <= bitcnt_s;
            shift_r   <= shift_s;
            bytecnt_r <= bytecnt_s;
            stage_b_r <= stage_b_s;
            stage_a_r <= stage_a_s;
        end
    end

    // Receiver next state: shift type + 8 data bits, then sample stop at bitcnt 9
    always_comb begin
        state_s  = state_r;
        bitcnt_s = bitcnt_r;
        shift_s  = shift_r;
        case (state_r)
            ST_IDLE: begin
                if (!sin) begin
                    state_s  = ST_RECV;
                    bitcnt_s = 4'd0;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (bitcnt_r == 4'd9) begin
                    state_s = ST_IDLE;
                end else begin
                    shift_s  = {shift_r[7:0], sin};
                    bitcnt_s = bitcnt_r + 4'd1;
                end
            end
            default: begin
                state_s  = ST_IDLE;
                bitcnt_s = 4'd0;
            end
        endcase
    end

    assign stop_s      = (state_r == ST_RECV) && (bitcnt_r == 4'd9);
    assign frame_bad_s = stop_s && !sin;
    assign data_ok_s   = stop_s && sin && !shift_r[8];
    assign cmd_ok_s    = stop_s && sin && shift_r[8];
    // Byte k of each word lands at bit 31-8k, i.e. slot (3 - k) * 8
    assign slot_s      = {~bytecnt_r[1:0], 3'b000};

    // Packet assembler: place data bytes, saturate the count, clear on command or framing fault
    always_comb begin
        bytecnt_s = bytecnt_r;
        stage_b_s = stage_b_r;
        stage_a_s = stage_a_r;
        if (frame_bad_s || cmd_ok_s) begin
            bytecnt_s = 4'd0;
            stage_b_s = 32'd0;
            stage_a_s = 32'd0;
        end else if (data_ok_s) begin
            if (bytecnt_r < FULL_CNT) begin
                if (!bytecnt_r[2]) begin
                    stage_b_s[slot_s +: 8] = shift_r[7:0];
                end else begin
                    stage_a_s[slot_s +: 8] = shift_r[7:0];
                end
            end else begin
                stage_b_s = stage_b_r;
            end
            if (bytecnt_r != SAT_CNT) begin
                bytecnt_s = bytecnt_r + 4'd1;
            end else begin
                bytecnt_s = bytecnt_r;
            end
        end else begin
            bytecnt_s = bytecnt_r;
        end
    end

    // Output stage: load on completion unless a held packet is not being taken
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_valid <= 1'b0;
            pkt_b     <= 32'd0;
            pkt_a     <= 32'd0;
            pkt_ctl   <= 8'd0;
            pkt_err   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= frame_bad_s;
            overrun   <= cmd_ok_s && pkt_valid && !pkt_ready;
            if (cmd_ok_s && (!pkt_valid || pkt_ready)) begin
                pkt_valid <= 1'b1;
                pkt_b     <= stage_b_r;
                pkt_a     <= stage_a_r;
                pkt_ctl   <= shift_r[7:0];
                pkt_err   <= (bytecnt_r != FULL_CNT);
            end else if (pkt_valid && pkt_ready) begin
                pkt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Directed bench for mtm_alu_deserializer: frames are driven on the falling edge,
// expected packets are queued at stimulus time and compared when the handshake fires.
module tb_mtm_alu_deserializer;

    logic        clk;
    logic        reset;
    logic        sin;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [31:0] pkt_b;
    logic [31:0] pkt_a;
    logic [7:0]  pkt_ctl;
    logic        pkt_err;
    logic        frame_err;
    logic        overrun;

    typedef struct packed {
        logic [31:0] b;
        logic [31:0] a;
        logic [7:0]  ctl;
        logic        err;
    } pkt_t;

    pkt_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   fe_cnt = 0;
    int   ov_cnt = 0;

    mtm_alu_deserializer #(.DATA_BYTES(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .sin       (sin),
        .pkt_valid (pkt_valid),
        .pkt_ready (pkt_ready),
        .pkt_b     (pkt_b),
        .pkt_a     (pkt_a),
        .pkt_ctl   (pkt_ctl),
        .pkt_err   (pkt_err),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [72:0] obs, input logic [72:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected packet: bytes base + k*step, first 8 placed MSB-first into B then A
    function automatic pkt_t exp_pkt(input logic [7:0] base, input logic [7:0] step,
                                     input int n, input logic [7:0] ctl);
        logic [63:0] ba;
        ba = 64'd0;
        for (int k = 0; k < 8; k++) begin
            if (k < n) ba[63 - 8*k -: 8] = base + 8'(k) * step;
        end
        return pkt_t'({ba, ctl, (n != 8)});
    endfunction

    task automatic send_frame(input logic typ, input logic [7:0] d, input logic stop, input int gap);
        logic [10:0] bits;
        bits = {1'b0, typ, d, stop};
        for (int i = 10; i >= 0; i--) begin
            @(negedge clk);
            sin = bits[i];
        end
        repeat (gap) begin
            @(negedge clk);
            sin = 1'b1;
        end
    endtask

    task automatic send_pkt(input logic [7:0] base, input logic [7:0] step, input int n,
                            input logic [7:0] ctl, input int gap, input int cmd_gap);
        for (int k = 0; k < n; k++) send_frame(1'b0, base + 8'(k) * step, 1'b1, gap);
        send_frame(1'b1, ctl, 1'b1, cmd_gap);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"}, 73'(pkt_valid), 73'd0);
        check({tag, "_b"}, 73'(pkt_b), 73'd0);
        check({tag, "_a"}, 73'(pkt_a), 73'd0);
        check({tag, "_ctl"}, 73'(pkt_ctl), 73'd0);
        check({tag, "_err"}, 73'(pkt_err), 73'd0);
        check({tag, "_frame_err"}, 73'(frame_err), 73'd0);
        check({tag, "_overrun"}, 73'(overrun), 73'd0);
    endtask

    // Scoreboard monitor: samples away from the rising edge
    always @(negedge clk) begin
        #2;
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (!reset && pkt_valid && pkt_ready) begin
            checks++;
            assert (q.size() > 0) else begin
                errors++;
                $error("FAIL pkt_unexpected: observed ctl=%h expected no packet", pkt_ctl);
            end
            if (q.size() > 0) begin
                pkt_t exp;
                exp = q.pop_front();
                check("pkt", {pkt_b, pkt_a, pkt_ctl, pkt_err}, exp);
            end
        end
    end

    initial begin
        reset     = 1'b1;
        sin       = 1'b1;
        pkt_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #3;
        check_outputs_zero("reset");

        // Nominal packet, then latency / single-cycle valid
        repeat (2) @(negedge clk);
        q.push_back(exp_pkt(8'h11, 8'h11, 8, 8'h01));
        send_pkt(8'h11, 8'h11, 8, 8'h01, 2, 0);
        @(negedge clk);
        sin = 1'b1;
        #3;
        check("nominal_valid_at_e10", 73'(pkt_valid), 73'd1);
        @(negedge clk);
        #3;
        check("nominal_valid_one_cycle", 73'(pkt_valid), 73'd0);
        repeat (2) @(negedge clk);

        // Short packet then nominal
        q.push_back(exp_pkt(8'h01, 8'h01, 7, 8'h05));
        send_pkt(8'h01, 8'h01, 7, 8'h05, 2, 2);
        q.push_back(exp_pkt(8'h11, 8'h11, 8, 8'h0A));
        send_pkt(8'h11, 8'h11, 8, 8'h0A, 2, 2);

        // Long packet
        q.push_back(exp_pkt(8'hA1, 8'h01, 9, 8'h09));
        send_pkt(8'hA1, 8'h01, 9, 8'h09, 2, 2);

        // Framing error after 3 good bytes, then clean packet
        for (int k = 0; k < 3; k++) send_frame(1'b0, 8'h30 + 8'(k), 1'b1, 2);
        send_frame(1'b0, 8'h3F, 1'b0, 2);
        #3;
        check("frame_err_pulse", 73'(fe_cnt), 73'd1);
        q.push_back(exp_pkt(8'h11, 8'h11, 8, 8'h04));
        send_pkt(8'h11, 8'h11, 8, 8'h04, 2, 2);
        #3;
        check("frame_err_one_cycle", 73'(fe_cnt), 73'd1);

        // Backpressure: second packet dropped
        pkt_ready = 1'b0;
        q.push_back(exp_pkt(8'h11, 8'h11, 8, 8'h01));
        send_pkt(8'h11, 8'h11, 8, 8'h01, 2, 0);
        send_pkt(8'h12, 8'h11, 8, 8'h02, 2, 3);
        #3;
        check("overrun_pulse", 73'(ov_cnt), 73'd1);
        check("bp_held_valid", 73'(pkt_valid), 73'd1);
        check("bp_held_ctl", 73'(pkt_ctl), 73'h01);
        @(negedge clk);
        pkt_ready = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        check("bp_valid_cleared", 73'(pkt_valid), 73'd0);
        check("bp_queue_drained", 73'(q.size()), 73'd0);
        check("overrun_one_cycle", 73'(ov_cnt), 73'd1);

        // Reset mid-frame with a held packet and 4 bytes staged
        pkt_ready = 1'b0;
        q.push_back(exp_pkt(8'h21, 8'h01, 8, 8'h03));
        send_pkt(8'h21, 8'h01, 8, 8'h03, 1, 1);
        for (int k = 0; k < 4; k++) send_frame(1'b0, 8'hC1 + 8'(k), 1'b1, 1);
        @(negedge clk); sin = 1'b0;
        @(negedge clk); sin = 1'b0;
        @(negedge clk); sin = 1'b1;
        @(negedge clk); sin = 1'b1;
        @(negedge clk); sin = 1'b0; reset = 1'b1;
        @(negedge clk); sin = 1'b1; reset = 1'b0;
        q.delete();
        #3;
        check_outputs_zero("midreset");
        pkt_ready = 1'b1;
        q.push_back(exp_pkt(8'h11, 8'h11, 8, 8'h06));
        send_pkt(8'h11, 8'h11, 8, 8'h06, 2, 2);

        // Back-to-back frames, no idle gap
        q.push_back(exp_pkt(8'h9A, 8'h13, 8, 8'h07));
        send_pkt(8'h9A, 8'h13, 8, 8'h07, 0, 0);
        q.push_back(exp_pkt(8'h5C, 8'h21, 8, 8'h08));
        send_pkt(8'h5C, 8'h21, 8, 8'h08, 0, 4);
        #3;
        check("final_queue_empty", 73'(q.size()), 73'd0);
        check("final_frame_err_count", 73'(fe_cnt), 73'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mtm_alu_deserializer.md
# mtm_alu_deserializer

Serial-input front end of the mtm_alu. Samples `sin` one bit per clock, recovers 11-bit frames (start, type, 8 data bits, stop), and assembles a packet of eight data bytes followed by one command byte into operands B, A and a control byte. The packet is presented to the ALU core on a valid/ready handshake. Framing and data-count faults are flagged alongside the packet.

## Interface
Parameters:
- `DATA_BYTES`, 8: data frames expected before a command frame. The first 4 form B, the next 4 form A. Fixed at 8; other values are unsupported.

Ports:
- `clk`  in  1  mtm_alu clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sin`  in  1  serial input; idle high.
- `pkt_valid`  out  1  packet held in output registers.
- `pkt_ready`  in  1  core accepts packet.
- `pkt_b`  out  32  operand B; first data byte is bits [31:24].
- `pkt_a`  out  32  operand A; fifth data byte is bits [31:24].
- `pkt_ctl`  out  8  command byte.
- `pkt_err`  out  1  data-count error; qualified by `pkt_valid`.
- `frame_err`  out  1  one-cycle pulse: a stop bit was sampled as 0.
- `overrun`  out  1  one-cycle pulse: a packet was dropped because the output was still occupied.

## Operation
- Frame bit order as sampled: start(0), type(1 = command, 0 = data), d[7] … d[0], stop(1).
- Receiver FSM:
  - IDLE: sample `sin` each edge. `sin==0` → RECV, `bitcnt=0`.
  - RECV: shift `sin` into a 9-bit register (type, d[7:0]) for `bitcnt` 0..8.
  - At `bitcnt==9` the stop bit is sampled and the FSM returns to IDLE. A new start may be sampled on the very next edge; no idle gap is required.
- Stop bit == 1: frame accepted, passed to the assembler.
- Stop bit == 0: frame discarded, `frame_err` pulses, assembler byte count cleared, partial packet abandoned.
- Packet assembler:
  - 4-bit `bytecnt`, saturating at 9.
  - Data frame: if `bytecnt<8`, store the byte at position `bytecnt` (MSB-first into B, then A). Increment `bytecnt` regardless of overflow.
  - Command frame: build the packet. `pkt_err = (bytecnt != 8)`. B/A take whatever bytes were stored; unfilled positions are 0. Then `bytecnt` and the staging registers clear to 0.
- Output stage:
  - Packet completion with `!pkt_valid`, or with `pkt_valid && pkt_ready` on the same edge: load the outputs and set `pkt_valid`.
  - Completion with `pkt_valid && !pkt_ready`: new packet dropped, `overrun` pulses, held packet unchanged.
  - `pkt_valid && pkt_ready` with no completion: `pkt_valid` clears. Data outputs keep their last value.
- Reset (any cycle, including mid-frame or with `pkt_valid` high): FSM to IDLE, all counters, staging and outputs to 0.

## Timing
- Reset values: `pkt_valid=0`, `pkt_b=0`, `pkt_a=0`, `pkt_ctl=0`, `pkt_err=0`, `frame_err=0`, `overrun=0`.
- Let E0 be the edge that samples the start bit. Stop is sampled at E10.
- `frame_err`, `overrun` and packet load are all registered at E10, so they are visible in the cycle after E10.
- Latency from command-frame start sample to `pkt_valid`: 10 edges.
- `frame_err` and `overrun` are high for exactly one cycle.
- Minimum frame period is 11 cycles, so at most one packet completion per 11 cycles.
- `pkt_valid` stays high until the handshake. No combinational path from `pkt_ready` to any output.
- `sin` is sampled at the rising edge. Upstream drives it on the falling edge, so there is half a cycle of setup.

## Test plan
- Nominal packet: data bytes 0x11,0x22,0x33,0x44,0x55,0x66,0x77,0x88, then command 0x01, with 2 idle cycles between frames and `pkt_ready=1` → `pkt_b=0x11223344`, `pkt_a=0x55667788`, `pkt_ctl=0x01`, `pkt_err=0`. `pkt_valid` high for 1 cycle, 10 edges after the command start sample.
- Short packet: 7 data bytes 0x01..0x07, then command 0x05 → `pkt_err=1`, `pkt_ctl=0x05`, `pkt_a=0x05060700`. Next nominal packet has `pkt_err=0`.
- Long packet: 9 data bytes, then command → `pkt_err=1`, first 8 bytes in B/A.
- Framing error: data frame with stop=0 after 3 good data bytes → `frame_err` 1-cycle pulse. A following nominal 8+1 packet is assembled cleanly with `pkt_err=0`.
- Backpressure: `pkt_ready=0`, two nominal packets back-to-back (ctl 0x01 then 0x02) → first held with `pkt_ctl=0x01`, `overrun` pulse at the second stop bit. Raising `pkt_ready` transfers ctl 0x01 only.
- Reset mid-frame: assert `reset` 1 cycle during the 5th bit of a data frame, after 4 bytes were received → all outputs 0. A following full packet decodes correctly with `pkt_err=0`, and back-to-back frames with zero idle cycles also decode correctly.
